// File: rtl/npu_sched_pkg.sv
// Shared types and constants for the NPU load scheduler.
// Line counts, region selects and per-region helpers.
package npu_sched_pkg;

    localparam int NPU_DATA_WIDTH = 256;
    localparam int WORD_W         = 16;
    localparam int WORDS_PER_LINE = NPU_DATA_WIDTH / WORD_W;
    localparam int CNT_W          = $clog2(WORDS_PER_LINE);
    localparam int HID_LINES      = 490;
    localparam int OUT_LINES      = 10;
    localparam int IN_LINES       = 49;
    localparam int NUM_RESULTS    = 10;
    localparam int ADDR_W         = 9;
    localparam int IDX_W          = 4;

    localparam logic [1:0] SEL_HID = 2'd0;
    localparam logic [1:0] SEL_OUT = 2'd1;
    localparam logic [1:0] SEL_IN  = 2'd2;

    localparam logic [ADDR_W-1:0] HID_LAST = ADDR_W'(HID_LINES - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_LINES - 1);
    localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_LINES - 1);

    typedef enum logic [2:0] {
        LOAD_HID,
        LOAD_OUT,
        LOAD_IN,
        START,
        COMPUTE,
        TX_REQ,
        TX_WAIT,
        DONE
    } state_e;

    function automatic logic [1:0] region_sel(state_e s);
        logic [1:0] sel;
        unique case (s)
            LOAD_OUT: sel = SEL_OUT;
            LOAD_IN:  sel = SEL_IN;
            default:  sel = SEL_HID;
        endcase
        return sel;
    endfunction

    function automatic logic [ADDR_W-1:0] region_last(state_e s);
        logic [ADDR_W-1:0] last;
        unique case (s)
            LOAD_OUT: last = OUT_LAST;
            LOAD_IN:  last = IN_LAST;
            default:  last = HID_LAST;
        endcase
        return last;
    endfunction

    function automatic state_e region_next(state_e s);
        state_e nxt;
        unique case (s)
            LOAD_HID: nxt = LOAD_OUT;
            LOAD_OUT: nxt = LOAD_IN;
            default:  nxt = START;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/npu_line_packer.sv
// Shifts 16-bit words into a 256-bit line, newest word on top.
// The line strobe is combinational with the 16th accepted word.
module npu_line_packer
    import npu_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      word_valid_i,
    input  logic [WORD_W-1:0]         word_data_i,
    output logic                      line_vld_o,
    output logic [NPU_DATA_WIDTH-1:0] line_o,
    output logic [CNT_W-1:0]          cnt_o
);

    logic [NPU_DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NPU_DATA_WIDTH-1:0] shifted;

    assign shifted = {word_data_i, buf_q[NPU_DATA_WIDTH-1:WORD_W]};

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (word_valid_i) begin
            buf_d = shifted;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign line_vld_o = word_valid_i && !flush_i &&
                        (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
    assign line_o     = shifted;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/npu_load_scheduler.sv
// NPU sequencer: loads weight/input stores, starts the core,
// then hands the 10 output results to the SPI slave one by one.
module npu_load_scheduler
    import npu_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      soft_reset,
    input  logic                      word_valid,
    input  logic [WORD_W-1:0]         word_data,
    input  logic                      debug_wr_en,
    input  logic [NPU_DATA_WIDTH-1:0] debug_data,
    output logic                      line_wr_en,
    output logic [1:0]                line_wr_sel,
    output logic [ADDR_W-1:0]         line_wr_addr,
    output logic [NPU_DATA_WIDTH-1:0] line_wr_data,
    output logic                      calc_start,
    input  logic                      calc_done,
    input  logic                      res_wr_en,
    input  logic [IDX_W-1:0]          res_wr_idx,
    input  logic [WORD_W-1:0]         res_wr_data,
    output logic                      start_transmission,
    output logic [WORD_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      proto_err
);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [IDX_W-1:0]          tx_idx_q, tx_idx_d;
    logic [1:0]                gap_q, gap_d;
    logic                      err_q, err_d;
    logic                      wr_en_q, wr_en_d;
    logic [1:0]                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [NPU_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      calc_start_q, calc_start_d;
    logic                      start_tx_q, start_tx_d;
    logic [WORD_W-1:0]         tx_data_q, tx_data_d;
    logic [WORD_W-1:0]         res_q [NUM_RESULTS];
    logic [WORD_W-1:0]         res_d [NUM_RESULTS];

    logic                      load;
    logic                      dbg;
    logic                      pk_line;
    logic [NPU_DATA_WIDTH-1:0] pk_data;
    logic [CNT_W-1:0]          pk_cnt;
    logic                      line_evt;
    logic [NPU_DATA_WIDTH-1:0] line_data;

    assign load = (state_q == LOAD_HID) || (state_q == LOAD_OUT) ||
                  (state_q == LOAD_IN);
    assign dbg  = load && debug_wr_en;

    // A debug line discards any partial word packing.
    npu_line_packer u_pack (
        .clk          (clk),
        .rst_ni       (reset_b),
        .flush_i      (soft_reset || dbg),
        .word_valid_i (load && word_valid),
        .word_data_i  (word_data),
        .line_vld_o   (pk_line),
        .line_o       (pk_data),
        .cnt_o        (pk_cnt)
    );

    assign line_evt  = dbg || pk_line;
    assign line_data = dbg ? debug_data : pk_data;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tx_idx_d     = tx_idx_q;
        gap_d        = gap_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        calc_start_d = 1'b0;
        start_tx_d   = 1'b0;
        tx_data_d    = tx_data_q;
        res_d        = res_q;
        unique case (state_q)
            LOAD_HID, LOAD_OUT, LOAD_IN: begin
                if (line_evt) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = region_sel(state_q);
                    wr_addr_d = addr_q;
                    wr_data_d = line_data;
                    if (addr_q == region_last(state_q)) begin
                        addr_d  = '0;
                        state_d = region_next(state_q);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                if (dbg && (word_valid || pk_cnt != '0)) err_d = 1'b1;
            end
            START: begin
                calc_start_d = 1'b1;
                state_d      = COMPUTE;
            end
            COMPUTE: begin
                if (res_wr_en) begin
                    if (res_wr_idx < IDX_W'(NUM_RESULTS))
                        res_d[res_wr_idx] = res_wr_data;
                    else
                        err_d = 1'b1;
                end
                if (calc_done) state_d = TX_REQ;
            end
            TX_REQ: begin
                tx_data_d  = res_q[tx_idx_q];
                start_tx_d = 1'b1;
                state_d    = TX_WAIT;
            end
            TX_WAIT: begin
                if (gap_q != 2'd0) begin
                    gap_d = gap_q - 2'd1;
                    if (gap_q == 2'd1) state_d = TX_REQ;
                end else if (tx_done) begin
                    tx_idx_d = tx_idx_q + IDX_W'(1);
                    if (tx_idx_q == IDX_W'(NUM_RESULTS - 1))
                        state_d = DONE;
                    else
                        gap_d = 2'd2;
                end
            end
            DONE: begin
            end
            default: state_d = LOAD_HID;
        endcase
        if (!load && (word_valid || debug_wr_en)) err_d = 1'b1;
        if (soft_reset) begin
            state_d   = LOAD_HID;
            addr_d    = '0;
            tx_idx_d  = '0;
            gap_d     = '0;
            err_d     = 1'b0;
            wr_en_d   = 1'b0;
            wr_sel_d  = '0;
            wr_addr_d = '0;
            wr_data_d = '0;
            calc_start_d = 1'b0;
            start_tx_d   = 1'b0;
            tx_data_d    = '0;
            res_d        = '{default: '0};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= LOAD_HID;
            addr_q       <= '0;
            tx_idx_q     <= '0;
            gap_q        <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            calc_start_q <= 1'b0;
            start_tx_q   <= 1'b0;
            tx_data_q    <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) res_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tx_idx_q     <= tx_idx_d;
            gap_q        <= gap_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            calc_start_q <= calc_start_d;
            start_tx_q   <= start_tx_d;
            tx_data_q    <= tx_data_d;
            res_q        <= res_d;
        end
    end

    assign line_wr_en         = wr_en_q;
    assign line_wr_sel        = wr_sel_q;
    assign line_wr_addr       = wr_addr_q;
    assign line_wr_data       = wr_data_q;
    assign calc_start         = calc_start_q;
    assign start_transmission = start_tx_q;
    assign tx_data            = tx_data_q;
    assign proto_err          = err_q;
    assign busy = !((state_q == LOAD_HID) && (pk_cnt == '0));

endmodule

// File: tb/tb_npu_load_scheduler.sv
// Self-checking bench for npu_load_scheduler.
// Directed vectors plus hand sequences for load, readout and resets.
module tb_npu_load_scheduler;
    import npu_sched_pkg::*;

    logic         clk = 1'b0;
    logic         reset_b, soft_reset, word_valid, debug_wr_en;
    logic [15:0]  word_data;
    logic [255:0] debug_data;
    logic         line_wr_en, calc_start, calc_done, res_wr_en;
    logic [1:0]   line_wr_sel;
    logic [8:0]   line_wr_addr;
    logic [255:0] line_wr_data;
    logic [3:0]   res_wr_idx;
    logic [15:0]  res_wr_data, tx_data;
    logic         start_transmission, tx_done, busy, proto_err;

    always #5 clk = ~clk;

    npu_load_scheduler dut (
        .clk(clk), .reset_b(reset_b), .soft_reset(soft_reset),
        .word_valid(word_valid), .word_data(word_data),
        .debug_wr_en(debug_wr_en), .debug_data(debug_data),
        .line_wr_en(line_wr_en), .line_wr_sel(line_wr_sel),
        .line_wr_addr(line_wr_addr), .line_wr_data(line_wr_data),
        .calc_start(calc_start), .calc_done(calc_done),
        .res_wr_en(res_wr_en), .res_wr_idx(res_wr_idx),
        .res_wr_data(res_wr_data),
        .start_transmission(start_transmission), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .proto_err(proto_err)
    );

    typedef struct packed {
        logic [1:0]   sel;
        logic [8:0]   addr;
        logic [255:0] data;
    } wr_t;

    typedef struct {
        logic        en;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        done;
        logic        exp_err;
        state_e      exp_st;
    } vec_t;

    wr_t wq[$];
    int  cyc = 0;
    int  last_line_cyc = 0;
    int  calc_cyc = 0;
    int  calc_cnt = 0;
    int  st_cnt = 0;
    int  errors = 0;
    int  checks = 0;

    always @(negedge clk) begin
        cyc++;
        if (line_wr_en) begin
            wq.push_back({line_wr_sel, line_wr_addr, line_wr_data});
            last_line_cyc = cyc;
        end
        if (calc_start) begin
            calc_cnt++;
            calc_cyc = cyc;
        end
        if (start_transmission) st_cnt++;
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic soft_pulse();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
    endtask

    task automatic send_dbg(input logic [255:0] d);
        debug_wr_en = 1'b1;
        debug_data  = d;
        tick();
        debug_wr_en = 1'b0;
    endtask

    task automatic send_words(input logic [15:0] base, input int n);
        word_valid = 1'b1;
        for (int j = 0; j < n; j++) begin
            word_data = base + 16'(j);
            tick();
        end
        word_valid = 1'b0;
    endtask

    function automatic logic [255:0] mk_line(input int sel, input int addr);
        logic [15:0] w;
        w = 16'(sel * 4096 + addr + 16'h0400);
        return {16{w}};
    endfunction

    function automatic logic [255:0] seq_line(input logic [15:0] base);
        logic [255:0] l;
        for (int j = 0; j < 16; j++) l[16*j +: 16] = base + 16'(j);
        return l;
    endfunction

    task automatic load_region(input int sel, input int n);
        for (int a = 0; a < n; a++) send_dbg(mk_line(sel, a));
    endtask

    task automatic full_load();
        load_region(0, 490);
        load_region(1, 10);
        load_region(2, 49);
    endtask

    task automatic check_seq(input int b);
        int bad = 0;
        int idx = b;
        int n;
        chk("seq_count", 256'(wq.size() - b), 256'(549));
        if (wq.size() - b == 549) begin
            for (int s = 0; s < 3; s++) begin
                n = (s == 0) ? 490 : (s == 1) ? 10 : 49;
                for (int a = 0; a < n; a++) begin
                    if (wq[idx].sel != 2'(s) || wq[idx].addr != 9'(a) ||
                        wq[idx].data != mk_line(s, a)) bad++;
                    idx++;
                end
            end
        end
        chk("seq_content", 256'(bad), 256'(0));
    endtask

    task automatic post_load_check(input int c0);
        tick();
        tick();
        chk("calc_once", 256'(calc_cnt - c0), 256'(1));
        chk("calc_lat", 256'(calc_cyc - last_line_cyc), 256'(1));
        chk("st_compute", 256'(dut.state_q), 256'(COMPUTE));
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!start_transmission && n < 20) begin
            tick();
            n++;
        end
        chk("tx_start_seen", 256'(start_transmission), 256'(1));
    endtask

    initial begin
        vec_t tv[11];
        int   b, c0, n, bad, s0;
        logic extra;

        for (int k = 0; k < 9; k++)
            tv[k] = '{1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0, 1'b0, COMPUTE};
        tv[9]  = '{1'b1, 4'd12, 16'hBEEF, 1'b0, 1'b1, COMPUTE};
        tv[10] = '{1'b1, 4'd9, 16'h1009, 1'b1, 1'b1, TX_REQ};

        reset_b = 1'b0; soft_reset = 1'b0; word_valid = 1'b0;
        word_data = '0; debug_wr_en = 1'b0; debug_data = '0;
        calc_done = 1'b0; res_wr_en = 1'b0; res_wr_idx = '0;
        res_wr_data = '0; tx_done = 1'b0;
        repeat (3) tick();
        reset_b = 1'b1;
        tick();
        chk("rst_wr_en", 256'(line_wr_en), 256'(0));
        chk("rst_addr", 256'(line_wr_addr), 256'(0));
        chk("rst_data", line_wr_data, 256'(0));
        chk("rst_calc", 256'(calc_start), 256'(0));
        chk("rst_stx", 256'(start_transmission), 256'(0));
        chk("rst_txd", 256'(tx_data), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_err", 256'(proto_err), 256'(0));
        chk("rst_state", 256'(dut.state_q), 256'(LOAD_HID));

        // Packed hidden load: word i = i
        b = wq.size();
        word_valid = 1'b1;
        for (int i = 0; i < 7840; i++) begin
            word_data = 16'(i);
            tick();
            if (i == 0) chk("busy_1word", 256'(busy), 256'(1));
            if (i == 14) chk("lat_pre", 256'(line_wr_en), 256'(0));
            if (i == 15) chk("lat_line", 256'(line_wr_en), 256'(1));
        end
        word_valid = 1'b0;
        tick();
        chk("hid_count", 256'(wq.size() - b), 256'(490));
        bad = 0;
        if (wq.size() - b == 490) begin
            for (int k = 0; k < 490; k++) begin
                if (wq[b+k].sel != SEL_HID || wq[b+k].addr != 9'(k)) bad++;
                for (int j = 0; j < 16; j++)
                    if (wq[b+k].data[16*j +: 16] != 16'(16*k + j)) bad++;
            end
            chk("hid_w0", 256'(wq[b].data[15:0]), 256'(16'h0000));
            chk("hid_w15", 256'(wq[b].data[255:240]), 256'(16'h000F));
        end
        chk("hid_lines", 256'(bad), 256'(0));
        chk("hid_state", 256'(dut.state_q), 256'(LOAD_OUT));
        chk("hid_err", 256'(proto_err), 256'(0));

        // Debug line after 3 packed words
        soft_pulse();
        b = wq.size();
        send_words(16'hAAA0, 3);
        send_dbg(mk_line(3, 77));
        chk("part_err", 256'(proto_err), 256'(1));
        send_words(16'h0100, 16);
        tick();
        chk("part_count", 256'(wq.size() - b), 256'(2));
        if (wq.size() - b == 2) begin
            chk("part_dbg", wq[b].data, mk_line(3, 77));
            chk("part_dbg_addr", 256'(wq[b].addr), 256'(0));
            chk("part_clean", wq[b+1].data, seq_line(16'h0100));
            chk("part_clean_addr", 256'(wq[b+1].addr), 256'(1));
        end

        // Word and debug line in the same cycle
        soft_pulse();
        chk("soft_err_clr", 256'(proto_err), 256'(0));
        b = wq.size();
        word_valid = 1'b1; word_data = 16'hDEAD;
        send_dbg(mk_line(2, 300));
        word_valid = 1'b0;
        chk("sim_err", 256'(proto_err), 256'(1));
        send_words(16'h0200, 16);
        tick();
        chk("sim_count", 256'(wq.size() - b), 256'(2));
        if (wq.size() - b == 2) begin
            chk("sim_dbg", wq[b].data, mk_line(2, 300));
            chk("sim_clean", wq[b+1].data, seq_line(16'h0200));
            chk("sim_clean_addr", 256'(wq[b+1].addr), 256'(1));
        end

        // Async reset mid LOAD_OUT, line 5 partially packed
        soft_pulse();
        load_region(0, 490);
        load_region(1, 5);
        send_words(16'h0300, 3);
        send_dbg(mk_line(1, 5));
        chk("out5_err", 256'(proto_err), 256'(1));
        send_words(16'h0400, 4);
        b = wq.size();
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_state", 256'(dut.state_q), 256'(LOAD_HID));
        chk("arst_addr", 256'(line_wr_addr), 256'(0));
        chk("arst_stx", 256'(start_transmission), 256'(0));
        chk("arst_err", 256'(proto_err), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        repeat (2) tick();
        reset_b = 1'b1;
        repeat (3) tick();
        chk("arst_no_partial", 256'(wq.size() - b), 256'(0));

        // Full reload via debug lines
        b = wq.size();
        c0 = calc_cnt;
        full_load();
        post_load_check(c0);
        check_seq(b);
        chk("load_err", 256'(proto_err), 256'(0));

        // Result writes from the core, table driven
        for (int k = 0; k < 11; k++) begin
            res_wr_en   = tv[k].en;
            res_wr_idx  = tv[k].idx;
            res_wr_data = tv[k].data;
            calc_done   = tv[k].done;
            tick();
            chk($sformatf("res_err_%0d", k), 256'(proto_err),
                256'(tv[k].exp_err));
            chk($sformatf("res_st_%0d", k), 256'(dut.state_q),
                256'(tv[k].exp_st));
        end
        res_wr_en = 1'b0;
        calc_done = 1'b0;

        // Readout handshake
        s0 = st_cnt;
        for (int k = 0; k < 10; k++) begin
            wait_start(n);
            if (k > 0) chk($sformatf("tx_gap_%0d", k), 256'(n), 256'(3));
            chk($sformatf("tx_data_%0d", k), 256'(tx_data),
                256'(16'h1000 + 16'(k)));
            extra = 1'b0;
            repeat (4) begin
                tick();
                extra = extra | start_transmission;
            end
            chk($sformatf("tx_gated_%0d", k), 256'(extra), 256'(0));
            chk($sformatf("tx_hold_%0d", k), 256'(tx_data),
                256'(16'h1000 + 16'(k)));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        tick();
        chk("tx_total", 256'(st_cnt - s0), 256'(10));
        chk("done_state", 256'(dut.state_q), 256'(DONE));
        chk("done_busy", 256'(busy), 256'(1));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (4) tick();
        chk("done_hold", 256'(dut.state_q), 256'(DONE));
        chk("done_no_tx", 256'(st_cnt - s0), 256'(10));

        soft_pulse();
        chk("sr_done_state", 256'(dut.state_q), 256'(LOAD_HID));
        chk("sr_done_busy", 256'(busy), 256'(0));

        // Soft reset while waiting in TX_WAIT
        c0 = calc_cnt;
        full_load();
        post_load_check(c0);
        res_wr_en = 1'b1; res_wr_idx = 4'd0; res_wr_data = 16'h2222;
        tick();
        res_wr_en = 1'b0;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        wait_start(n);
        chk("tw_data", 256'(tx_data), 256'(16'h2222));
        word_valid = 1'b1; word_data = 16'h5555;
        tick();
        word_valid = 1'b0;
        chk("tw_late_err", 256'(proto_err), 256'(1));
        chk("tw_state", 256'(dut.state_q), 256'(TX_WAIT));
        soft_pulse();
        chk("sr_tw_state", 256'(dut.state_q), 256'(LOAD_HID));
        chk("sr_tw_addr", 256'(line_wr_addr), 256'(0));
        chk("sr_tw_stx", 256'(start_transmission), 256'(0));
        chk("sr_tw_err", 256'(proto_err), 256'(0));
        chk("sr_tw_txd", 256'(tx_data), 256'(0));

        b = wq.size();
        c0 = calc_cnt;
        full_load();
        post_load_check(c0);
        check_seq(b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
